parking_gate_arbiter: RTL
=========================

// Module: parking_gate_arbiter
// PURPOSE
//  Shares the single barrier gate of the car park between the entrance lane and the exit lane.
//  Sequences each entry through a password check.
//  Tracks lot occupancy against a fixed capacity and drives GREEN_LED/RED_LED.
//  Sits between the lane sensors / password checker and the gate actuator.
// PARAMETERS
//  CAPACITY          8   number of parking spaces; 1..(2**CNT_W - 1)
//  CNT_W             4   occupancy counter width
//  GATE_OPEN_CYCLES  16  cycles the gate stays open per granted car (also REJECT hold time); >=1
//  PASS_TIMEOUT      64  cycles allowed in WAIT_PASS for a password verdict; >=1
//  TIMER_W           8   timer width; 2**TIMER_W > max(GATE_OPEN_CYCLES, PASS_TIMEOUT)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      synchronous, active-high
//  entry_req    in   1      level: car present at entrance sensor
//  exit_req     in   1      level: car present at exit sensor
//  pass_valid   in   1      1-cycle strobe: password verdict available
//  pass_ok      in   1      verdict, qualified by pass_valid (1 = correct)
//  gate_open    out  1      barrier open command
//  grant_entry  out  1      gate currently owned by entrance lane (WAIT_PASS or OPEN_IN)
//  grant_exit   out  1      gate currently owned by exit lane (OPEN_OUT)
//  GREEN_LED    out  1      1 in OPEN_IN / OPEN_OUT
//  RED_LED      out  1      1 in WAIT_PASS / REJECT
//  pass_fail    out  1      1-cycle pulse on the WAIT_PASS->REJECT transition
//  occupancy    out  CNT_W  cars currently parked
//  full         out  1      occupancy == CAPACITY
//  empty        out  1      occupancy == 0
// BEHAVIOUR
//  Reset:
//   - state=IDLE, timer=0, occupancy=0, last_served=ENTRY.
//   - All outputs 0 except empty=1.
//   - Applies mid-operation too: any open gate closes the next cycle; no occupancy update completes.
//  Outputs:
//   - Decoded combinationally from the state register and occupancy register.
//   - Valid in the cycle after the clock edge that enters the state.
//  FSM states: IDLE, WAIT_PASS, OPEN_IN, OPEN_OUT, REJECT.
//   IDLE
//    - eligible_in  = entry_req & ~full
//    - eligible_out = exit_req & ~empty
//    - Only eligible_in -> WAIT_PASS. Only eligible_out -> OPEN_OUT.
//    - Both -> serve the lane opposite last_served.
//    - Neither -> stay. entry_req while full is ignored; exit_req while empty is ignored.
//    - pass_valid in IDLE is ignored.
//   WAIT_PASS (timer counts from 0)
//    - pass_valid & pass_ok -> OPEN_IN.
//    - pass_valid & ~pass_ok -> REJECT, with pass_fail pulse.
//    - else entry_req==0 or timer==PASS_TIMEOUT-1 -> IDLE (abandon; last_served unchanged).
//    - A verdict takes precedence over a same-cycle abandon.
//   OPEN_IN
//    - Gate held GATE_OPEN_CYCLES cycles.
//    - On the last cycle (timer==GATE_OPEN_CYCLES-1): occupancy+1, last_served=ENTRY, -> IDLE.
//   OPEN_OUT
//    - As OPEN_IN, but occupancy-1 and last_served=EXIT.
//   REJECT
//    - RED held GATE_OPEN_CYCLES cycles, then -> IDLE. last_served=ENTRY; occupancy unchanged.
//  Timer and latency:
//   - Timer clears on every state change and increments otherwise.
//   - Sensor changes outside IDLE/WAIT_PASS are ignored; the gate is never preempted.
//   - Latency: a request sampled at edge k in IDLE sets grant_* after edge k.
//   - An exit with the gate free opens the gate after edge k.
//  Occupancy:
//   - Unsigned CNT_W bits; changes by at most 1 per cycle.
//   - Never exceeds CAPACITY or goes below 0, by construction: full blocks entry, empty blocks exit.
//   - Gate-level invariant: grant_entry & grant_exit == 0.
// TESTING
//  1. reset 3 cycles -> all outputs 0, empty=1, occupancy=0; reset asserted in OPEN_IN -> IDLE next cycle, occupancy unchanged.
//  2. entry_req=1, pass_valid+pass_ok at 5th WAIT_PASS cycle -> OPEN_IN, GREEN_LED 16 cycles, occupancy 0->1.
//  3. entry_req=1, pass_valid with pass_ok=0 -> single pass_fail pulse, RED 16 cycles, occupancy unchanged; no verdict for 64 cycles -> IDLE.
//  4. fill to 8 cars -> full=1; entry_req ignored (stays IDLE); exit_req -> OPEN_OUT, occupancy 8->7, full=0.
//  5. entry_req and exit_req asserted together from IDLE after reset, occupancy=3 -> exit served first, then entry; alternation verified over 4 rounds.
//  6. exit_req with occupancy=0 -> no grant, gate_open stays 0; pass_valid in IDLE -> no state change.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Single-barrier arbiter for a car park: alternates the gate between the entrance
// lane (via password check) and the exit lane, and tracks occupancy against CAPACITY.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY         = 8,
  parameter int unsigned CNT_W            = 4,
  parameter int unsigned GATE_OPEN_CYCLES = 16,
  parameter int unsigned PASS_TIMEOUT     = 64,
  parameter int unsigned TIMER_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             pass_valid,
  input  logic             pass_ok,
  output logic             gate_open,
  output logic             grant_entry,
  output logic             grant_exit,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic             pass_fail,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PASS,
    OPEN_IN,
    OPEN_OUT,
    REJECT
  } state_t;

  typedef enum logic {
    LANE_ENTRY,
    LANE_EXIT
  } lane_t;

  localparam logic [TIMER_W-1:0] GATE_LAST = TIMER_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PASS_LAST = TIMER_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CAP       = CNT_W'(CAPACITY);

  state_t             state;
  lane_t              last_served;
  logic [TIMER_W-1:0] timer;
  logic               eligible_in;
  logic               eligible_out;

  assign full         = (occupancy == CAP);
  assign empty        = (occupancy == '0);
  assign eligible_in  = entry_req & ~full;
  assign eligible_out = exit_req & ~empty;

  // Every branch that changes state also clears the timer; otherwise it free-runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      occupancy   <= '0;
      last_served <= LANE_ENTRY;
    end else begin
      timer <= timer + 1'b1;
      case (state)
        IDLE: begin
          if (eligible_in && (!eligible_out || last_served == LANE_EXIT)) begin
            state <= WAIT_PASS;
            timer <= '0;
          end else if (eligible_out) begin
            state <= OPEN_OUT;
            timer <= '0;
          end
        end
        WAIT_PASS: begin
          if (pass_valid) begin
            state <= pass_ok ? OPEN_IN : REJECT;
            timer <= '0;
            if (!pass_ok) last_served <= LANE_ENTRY;
          end else if (!entry_req || timer == PASS_LAST) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        OPEN_IN: begin
          if (timer == GATE_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            occupancy   <= occupancy + 1'b1;
            last_served <= LANE_ENTRY;
          end
        end
        OPEN_OUT: begin
          if (timer == GATE_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            occupancy   <= occupancy - 1'b1;
            last_served <= LANE_EXIT;
          end
        end
        REJECT: begin
          if (timer == GATE_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            last_served <= LANE_ENTRY;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  // pass_fail marks the first REJECT cycle, i.e. the cycle after the failing verdict.
  always_comb begin
    gate_open   = (state == OPEN_IN) || (state == OPEN_OUT);
    grant_entry = (state == WAIT_PASS) || (state == OPEN_IN);
    grant_exit  = (state == OPEN_OUT);
    GREEN_LED   = (state == OPEN_IN) || (state == OPEN_OUT);
    RED_LED     = (state == WAIT_PASS) || (state == REJECT);
    pass_fail   = (state == REJECT) && (timer == '0);
  end

endmodule
